// File: rtl/spi_byte_receiver_if.sv
// -----------------------------------------------------------------------------
// spi_byte_receiver_if
// Groups the external SPI pins and the byte-delivery strobes of the SPI
// byte receiver into one bundle.
//   spi_sclk_in   SPI clock, asynchronous, idle low (mode 0)
//   spi_mosi_in   SPI data, asynchronous, sampled on SCLK rising edge
//   spi_cs_n_in   chip select, asynchronous, active low
//   spi_rdy_out   one-cycle strobe: new byte on spi_data_out
//   spi_data_out  last completed byte, held until the next one
//   spi_err_out   one-cycle strobe: frame ended on a partial byte
// master: the side driving the pins and consuming bytes.
// slave : the receiver itself.
// -----------------------------------------------------------------------------
interface spi_byte_receiver_if;
  logic       spi_sclk_in;
  logic       spi_mosi_in;
  logic       spi_cs_n_in;
  logic       spi_rdy_out;
  logic [7:0] spi_data_out;
  logic       spi_err_out;

  modport master (
    output spi_sclk_in, spi_mosi_in, spi_cs_n_in,
    input  spi_rdy_out, spi_data_out, spi_err_out
  );

  modport slave (
    input  spi_sclk_in, spi_mosi_in, spi_cs_n_in,
    output spi_rdy_out, spi_data_out, spi_err_out
  );
endinterface

// File: rtl/spi_byte_receiver.sv
// -----------------------------------------------------------------------------
// spi_byte_receiver
// Front end between the SPI pins and the layer control logic. Brings the
// asynchronous mode-0 SCLK/MOSI/CS# into the clk_in domain, deserialises MOSI
// MSB-first into bytes, strobes each completed byte, and flags frames that
// end with 1..7 bits pending.
//   clk_in    system clock (at least 4x the maximum SCLK frequency)
//   rst_n_in  asynchronous active-low reset
//   bus       spi_byte_receiver_if.slave (SPI pins in, byte strobes out)
// Parameter SYNC_STAGES (2..4): synchroniser depth, identical on all inputs.
// -----------------------------------------------------------------------------
module spi_byte_receiver #(
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  spi_byte_receiver_if.slave  bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Synchronisers. Equal depth on all three chains keeps mosi_s and cs_s
  // aligned with the SCLK rising edge detected from sclk_s/sclk_d.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic                   sclk_d;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      // NOTE: the CS# chain resets to 1 (deselected) so a frame already in
      // progress at release is seen as a fresh high-to-low transition later,
      // never as a phantom frame starting inside reset.
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      sclk_d    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every stage take the previous
      // stage's old value, which is what makes this a shift chain.
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.spi_sclk_in};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi_in};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0],   bus.spi_cs_n_in};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
    end
  end

  logic sclk_s;
  logic mosi_s;
  logic cs_s;
  logic rise;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign rise   = sclk_s & ~sclk_d;

  // ---------------------------------------------------------------------------
  // FSM: state register / next-state / outputs
  // ---------------------------------------------------------------------------
  state_t     state;
  state_t     state_next;
  logic [2:0] bit_cnt;
  logic [7:0] shift_reg;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_next;
  end

  // Frame membership is decided by CS# alone; SCLK never moves the FSM.
  always_comb begin
    state_next = cs_s ? IDLE : SHIFT;
  end

  logic clear;
  logic shift_en;
  logic byte_done;
  logic frame_err;

  always_comb begin
    // NOTE: defaults first so every path assigns every output; without them
    // a missed branch would infer a latch.
    clear     = 1'b0;
    shift_en  = 1'b0;
    byte_done = 1'b0;
    frame_err = 1'b0;
    unique case (state)
      IDLE: clear = 1'b1;
      SHIFT: begin
        // CS release wins over a coincident SCLK edge: the edge is dropped
        // and the error decision uses the count from before it.
        shift_en  = rise & ~cs_s;
        byte_done = shift_en & (bit_cnt == 3'd7);
        frame_err = cs_s & (bit_cnt != 3'd0);
      end
      default: clear = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  logic       rdy;
  logic       err;
  logic [7:0] data;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
      rdy       <= 1'b0;
      err       <= 1'b0;
      data      <= '0;
    end else begin
      rdy <= byte_done;
      err <= frame_err;
      if (clear) begin
        bit_cnt   <= '0;
        shift_reg <= '0;
      end else if (shift_en) begin
        shift_reg <= {shift_reg[6:0], mosi_s};
        // 3-bit counter wraps 7 -> 0, so back-to-back bytes need no gap.
        bit_cnt   <= bit_cnt + 3'd1;
      end
      if (byte_done) data <= {shift_reg[6:0], mosi_s};
    end
  end

  assign bus.spi_rdy_out  = rdy;
  assign bus.spi_err_out  = err;
  assign bus.spi_data_out = data;

endmodule

// File: tb/tb_spi_byte_receiver.sv
// -----------------------------------------------------------------------------
// tb_spi_byte_receiver
// Directed bench for spi_byte_receiver. Bytes sent are pushed to a scoreboard
// queue; a negedge monitor pops and compares each strobed byte and counts
// rdy/err pulses for the directed steps to check.
// -----------------------------------------------------------------------------
module tb_spi_byte_receiver;

  localparam int SYNC = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  spi_byte_receiver_if bus ();

  spi_byte_receiver #(
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         rdy_cnt = 0;
  int         err_cnt = 0;
  logic [7:0] exp_q[$];
  int         rdy_cyc_q[$];
  logic       prev_rdy = 1'b0;
  logic       prev_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.spi_rdy_out) begin
        rdy_cnt++;
        rdy_cyc_q.push_back(cyc);
        check("rdy_err_overlap", 32'(bus.spi_err_out), 0);
        check("rdy_back_to_back", 32'(prev_rdy), 0);
        if (exp_q.size() == 0) check("rdy_unexpected", 32'(bus.spi_rdy_out), 0);
        else                   check("rdy_data", 32'(bus.spi_data_out), 32'(exp_q.pop_front()));
      end
      if (bus.spi_err_out) begin
        err_cnt++;
        check("err_back_to_back", 32'(prev_err), 0);
      end
    end
    prev_rdy <= bus.spi_rdy_out;
    prev_err <= bus.spi_err_out;
  end

  task automatic send_bit(input logic b, input int hi, input int lo);
    bus.spi_mosi_in = b;
    repeat (lo) @(negedge clk);
    bus.spi_sclk_in = 1'b1;
    repeat (hi) @(negedge clk);
    bus.spi_sclk_in = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v, input int hi, input int lo);
    exp_q.push_back(v);
    for (int i = 7; i >= 0; i--) send_bit(v[i], hi, lo);
  endtask

  task automatic cs_low();
    @(negedge clk);
    bus.spi_cs_n_in = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (3) @(negedge clk);
    bus.spi_cs_n_in = 1'b1;
    repeat (SYNC + 4) @(negedge clk);
  endtask

  initial begin
    int r0;
    int e0;
    int lat;
    logic [7:0] b2b[4];
    logic [7:0] a5;

    bus.spi_sclk_in = 1'b0;
    bus.spi_mosi_in = 1'b0;
    bus.spi_cs_n_in = 1'b1;
    b2b = '{8'h00, 8'hFF, 8'h3C, 8'h81};
    a5  = 8'hA5;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_rdy", 32'(bus.spi_rdy_out), 0);
    check("reset_err", 32'(bus.spi_err_out), 0);
    check("reset_data", 32'(bus.spi_data_out), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single byte 0xA5 at clk/8, with latency measured on the 8th rise
    r0 = rdy_cnt;
    e0 = err_cnt;
    cs_low();
    exp_q.push_back(a5);
    for (int i = 7; i >= 1; i--) send_bit(a5[i], 4, 4);
    bus.spi_mosi_in = a5[0];
    repeat (4) @(negedge clk);
    bus.spi_sclk_in = 1'b1;
    lat = 0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      if (bus.spi_rdy_out && lat == 0) lat = k;
    end
    check("a5_latency", 32'(lat), 32'(SYNC + 1));
    @(negedge clk);
    bus.spi_sclk_in = 1'b0;
    cs_high();
    check("a5_rdy_count", 32'(rdy_cnt - r0), 1);
    check("a5_no_err", 32'(err_cnt - e0), 0);
    check("a5_data_held", 32'(bus.spi_data_out), 32'h A5);

    // Back-to-back bytes in one frame
    r0 = rdy_cnt;
    e0 = err_cnt;
    cs_low();
    foreach (b2b[i]) send_byte(b2b[i], 4, 4);
    cs_high();
    check("b2b_rdy_count", 32'(rdy_cnt - r0), 4);
    check("b2b_no_err", 32'(err_cnt - e0), 0);
    check("b2b_data_held", 32'(bus.spi_data_out), 32'h81);

    // Partial frame 10110 then CS# high
    r0 = rdy_cnt;
    e0 = err_cnt;
    cs_low();
    send_bit(1'b1, 4, 4);
    send_bit(1'b0, 4, 4);
    send_bit(1'b1, 4, 4);
    send_bit(1'b1, 4, 4);
    send_bit(1'b0, 4, 4);
    cs_high();
    check("partial_err_count", 32'(err_cnt - e0), 1);
    check("partial_no_rdy", 32'(rdy_cnt - r0), 0);
    check("partial_data_kept", 32'(bus.spi_data_out), 32'h81);

    // Recovery frame 0xC3
    r0 = rdy_cnt;
    e0 = err_cnt;
    cs_low();
    send_byte(8'hC3, 4, 4);
    cs_high();
    check("c3_rdy_count", 32'(rdy_cnt - r0), 1);
    check("c3_no_err", 32'(err_cnt - e0), 0);
    check("c3_data", 32'(bus.spi_data_out), 32'hC3);

    // Minimum SCLK timing: 2 high / 2 low
    r0 = rdy_cnt;
    e0 = err_cnt;
    rdy_cyc_q.delete();
    cs_low();
    send_byte(8'h01, 2, 2);
    send_byte(8'h80, 2, 2);
    cs_high();
    check("min_rdy_count", 32'(rdy_cnt - r0), 2);
    check("min_no_err", 32'(err_cnt - e0), 0);
    if (rdy_cyc_q.size() >= 2)
      check("min_rdy_spacing", 32'(rdy_cyc_q[1] - rdy_cyc_q[0]), 32);

    // SCLK noise while deselected
    r0 = rdy_cnt;
    e0 = err_cnt;
    for (int t = 0; t < 20; t++) begin
      bus.spi_mosi_in = 1'($urandom);
      repeat (2) @(negedge clk);
      bus.spi_sclk_in = ~bus.spi_sclk_in;
    end
    repeat (SYNC + 4) @(negedge clk);
    check("noise_no_rdy", 32'(rdy_cnt - r0), 0);
    check("noise_no_err", 32'(err_cnt - e0), 0);
    check("noise_data_kept", 32'(bus.spi_data_out), 32'h80);

    // Reset mid-byte with CS# low and 3 bits shifted
    cs_low();
    send_bit(1'b1, 4, 4);
    send_bit(1'b1, 4, 4);
    send_bit(1'b0, 4, 4);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_rdy", 32'(bus.spi_rdy_out), 0);
    check("midrst_err", 32'(bus.spi_err_out), 0);
    check("midrst_data", 32'(bus.spi_data_out), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    e0 = err_cnt;
    repeat (4) @(negedge clk);
    cs_high();
    check("midrst_release_no_err", 32'(err_cnt - e0), 0);

    // Full frame 0x5A after reset
    r0 = rdy_cnt;
    e0 = err_cnt;
    cs_low();
    send_byte(8'h5A, 4, 4);
    cs_high();
    check("post_rst_rdy_count", 32'(rdy_cnt - r0), 1);
    check("post_rst_no_err", 32'(err_cnt - e0), 0);
    check("post_rst_data", 32'(bus.spi_data_out), 32'h5A);

    check("queue_drained", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_byte_receiver.md
# spi_byte_receiver

- Front-end stage between the external SPI pins and the layer control logic.
- Synchronises the asynchronous SPI mode-0 signals (SCLK, MOSI, CS#) into the system clock domain and deserialises MOSI MSB-first into bytes.
- Presents each completed byte with a one-cycle ready strobe.
- Flags frames that end on a partial byte.

## Interface
Parameters:
- SYNC_STAGES, 2: synchroniser depth applied identically to SCLK, MOSI and CS#; legal range 2..4.

Ports:
- clk_in  input  1  system clock (PLL output, ≥ 4× max SCLK frequency)
- rst_n_in  input  1  reset; one clock; reset is asynchronous and active-low
- spi_sclk_in  input  1  SPI clock, asynchronous, idle low (mode 0)
- spi_mosi_in  input  1  SPI data, asynchronous, sampled on SCLK rising edge
- spi_cs_n_in  input  1  chip select, asynchronous, active low
- spi_rdy_out  output  1  one-cycle strobe: new byte on spi_data_out
- spi_data_out  output  8  last completed byte, held until next byte
- spi_err_out  output  1  one-cycle strobe: CS# deasserted with 1..7 bits pending

## Operation
- Synchronisation:
  - Each input passes through its own SYNC_STAGES flip-flop chain; the last stage is named *_s.
  - One extra register on sclk_s gives sclk_d.
  - rise = sclk_s & ~sclk_d.
  - MOSI and CS# chains have equal depth, so mosi_s is aligned with the detected edge.
- States: IDLE (cs_s = 1) and SHIFT (cs_s = 0). Transitions are decided only by cs_s.
- In IDLE:
  - bit_cnt = 0, shift register = 0.
  - rise is ignored.
- In SHIFT, on rise:
  - shift_reg = {shift_reg[6:0], mosi_s}.
  - bit_cnt increments modulo 8.
- When rise occurs with bit_cnt = 7:
  - Next cycle: spi_data_out = {shift_reg[6:0], mosi_s} and spi_rdy_out = 1.
  - bit_cnt wraps to 0, so back-to-back bytes in one frame need no gap.
- SHIFT→IDLE with bit_cnt ≠ 0:
  - Partial byte is discarded; spi_data_out is unchanged and no rdy is issued.
  - spi_err_out = 1 for one cycle.
- SHIFT→IDLE with bit_cnt = 0: no err.
- Simultaneous rise and cs_s rising in the same cycle: CS wins. The edge is ignored, and err follows the bit_cnt value before that edge.
- spi_rdy_out and spi_err_out are never asserted in the same cycle, and are never asserted for two consecutive cycles.
- SCLK edges while CS# is high have no effect on any output.
- Reset values:
  - spi_rdy_out = 0, spi_err_out = 0, spi_data_out = 8'h00.
  - All synchroniser stages = 0, except the CS# chain = 1.
  - State = IDLE, bit_cnt = 0.

## Timing
- Reset mid-byte: all state clears immediately (asynchronous). After release, the block waits in IDLE until cs_s is observed high then low.
  - A frame already in progress at release starts counting at the first rise seen with cs_s = 0.
  - Byte alignment of such a frame is not guaranteed and is the software's responsibility.
- Latency, with cycle 0 as the first clk_in edge sampling the 8th SCLK rising edge high:
  - rise is detected in cycle SYNC_STAGES.
  - spi_rdy_out is high in cycle SYNC_STAGES+1.
  - Total: SYNC_STAGES+1 clocks (3 at default).
- CS# deassert to spi_err_out: SYNC_STAGES+1 clocks, same pipeline.
- Input constraints:
  - SCLK high and low phases each ≥ 2 clk_in periods.
  - MOSI stable from 1 clk_in period before to 1 period after each SCLK rising edge.
  - CS# falling ≥ 2 clk_in periods before the first SCLK rise.
  - CS# rising ≥ 2 clk_in periods after the last SCLK rise.
- Downstream sees at most one spi_rdy_out per 32 clk_in cycles at maximum SCLK.
- spi_data_out is valid whenever spi_rdy_out is high and stable between strobes.

## Test plan
- Reset: assert rst_n_in mid-simulation with CS# low and 3 bits shifted → all outputs 0 at once. A later full frame containing 0x5A → single rdy, data 0x5A, no err.
- Single byte: CS# low, send 0xA5 with SCLK = clk_in/8 → one rdy pulse exactly 3 clocks after the 8th sampled rise, data 0xA5, no err at CS# rise.
- Back-to-back bytes: one frame with 0x00, 0xFF, 0x3C, 0x81, no inter-byte gap → four rdy pulses with those values in order. spi_data_out holds 0x81 after CS# rise.
- Partial frame: 5 bits (10110) then CS# high → no rdy, one err pulse, spi_data_out unchanged. Next frame 0xC3 → data 0xC3, no err.
- Minimum timing: SCLK at 2-high/2-low clk_in periods, bytes 0x01 and 0x80 → both received correctly with rdy pulses 32 clocks apart.
- CS# idle noise: 20 SCLK toggles with random MOSI while CS# high → no rdy, no err, spi_data_out unchanged.
